gwct_uart_cmd: RTL



---
 rtl/gwct_uart_cmd_pkg.sv | 38 +++
 rtl/gwct_uart_cmd_if.sv | 33 +++
 rtl/gwct_uart_cmd_timer.sv | 49 ++++
 rtl/gwct_uart_cmd.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gwct_uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// gwct_uart_cmd_pkg
// Shared definitions for the UART command engine: FSM state encoding, command
// opcodes, response bytes and a counter-width helper for the timeout timers.
//
// Build option: GWCT_UART_CMD_CSUM_EN adds the GET_CSUM state used when every
// W/R command carries a trailing XOR checksum byte.
// -----------------------------------------------------------------------------
package gwct_uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_DATA = 3'd2,
        ST_BUS_WR   = 3'd3,
        ST_BUS_RD   = 3'd4,
        ST_WAIT_RD  = 3'd5,
        ST_SEND     = 3'd6
`ifdef GWCT_UART_CMD_CSUM_EN
        ,ST_GET_CSUM = 3'd7
`endif
    } state_e;

    localparam logic [7:0] OP_WR   = 8'h57;  // 'W'
    localparam logic [7:0] OP_RD   = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

    // Bits needed to count 0 .. limit-1; never below one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction

    function automatic logic is_cmd_op(input logic [7:0] op);
        return (op == OP_WR) || (op == OP_RD);
    endfunction

endpackage

// File: rtl/gwct_uart_cmd_if.sv
// -----------------------------------------------------------------------------
// gwct_uart_cmd_if
// Bundles the UART byte handshake and the 8-bit register bus seen by the
// command engine.
//   master : the command engine (consumes rx bytes, drives tx and the bus)
//   slave  : the environment (UART core + register file)
// Signals: rx_data/rx_valid (byte in), tx_data/tx_valid/tx_ready (byte out),
//          reg_addr/reg_wdata/reg_we/reg_re (bus request),
//          reg_rdata/reg_rvalid (bus read return).
// -----------------------------------------------------------------------------
interface gwct_uart_cmd_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       reg_rvalid;

    modport master (
        input  rx_data, rx_valid, tx_ready, reg_rdata, reg_rvalid,
        output tx_data, tx_valid, reg_addr, reg_wdata, reg_we, reg_re
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, reg_rdata, reg_rvalid,
        input  tx_data, tx_valid, reg_addr, reg_wdata, reg_we, reg_re
    );
endinterface

// File: rtl/gwct_uart_cmd_timer.sv
// -----------------------------------------------------------------------------
// gwct_uart_cmd_timer
// Idle-cycle timer. Counts cycles while en=1 and clear=0; held at zero
// otherwise. expire pulses on the LIMIT-th consecutive counted cycle. A clear in
// that same cycle suppresses the pulse, so a late event still wins.
// Ports: clk, rst (async, active-high), en, clear -> expire.
// -----------------------------------------------------------------------------
module gwct_uart_cmd_timer
    import gwct_uart_cmd_pkg::*;
#(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic expire
);

    localparam int               CNT_W = cnt_width(LIMIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || clear) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign expire = en && !clear && (cnt_q == LAST);

    // NOTE: state registers use non-blocking assignments so all flops update
    // together from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gwct_uart_cmd.sv
// -----------------------------------------------------------------------------
// gwct_uart_cmd
// Binary command engine between a UART byte interface and an 8-bit register
// bus.  Commands:  'W' addr data -> 'K'     'R' addr -> read byte
// Unknown opcode -> 'E'.  Bus read timeout -> 'E'.  Inter-byte timeout drops the
// partial command silently.  Errors bump a saturating 8-bit counter (at most
// once per cycle).
//
// Build option: GWCT_UART_CMD_CSUM_EN -- W/R commands carry a trailing byte equal
// to the XOR of all preceding command bytes; a mismatch answers 'E' with no bus
// access.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   bus           gwct_uart_cmd_if.master (UART rx/tx handshake + register bus)
//   busy          high whenever the FSM is not in IDLE
//   err_cnt       saturating error counter
// Parameters:
//   TIMEOUT_CYC     idle cycles allowed between bytes of one command
//   RD_TIMEOUT_CYC  cycles to wait for reg_rvalid after reg_re
// -----------------------------------------------------------------------------
module gwct_uart_cmd
    import gwct_uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC    = 5_000_000,
    parameter int RD_TIMEOUT_CYC = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    gwct_uart_cmd_if.master      bus,
    output logic                 busy,
    output logic [7:0]           err_cnt
);

    state_e     state_q, state_d;
    logic [7:0] op_q,    op_d;
    logic [7:0] addr_q,  addr_d;
    logic [7:0] data_q,  data_d;
    logic [7:0] resp_q,  resp_d;
    logic [7:0] err_q,   err_d;
`ifdef GWCT_UART_CMD_CSUM_EN
    logic [7:0] csum_q,  csum_d;
`endif

    logic err_inc;
    logic reg_we;
    logic reg_re;
    logic tx_valid;
    logic ib_en;
    logic ib_expire;
    logic rd_en;
    logic rd_expire;

    // Inter-byte timer: runs in every byte-collecting state; any received byte
    // there is accepted and restarts it.
    always_comb begin
        ib_en = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
`ifdef GWCT_UART_CMD_CSUM_EN
        ib_en = ib_en || (state_q == ST_GET_CSUM);
`endif
    end

    assign rd_en = (state_q == ST_WAIT_RD);

    gwct_uart_cmd_timer #(.LIMIT(TIMEOUT_CYC)) u_ib_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (ib_en),
        .clear  (bus.rx_valid),
        .expire (ib_expire)
    );

    gwct_uart_cmd_timer #(.LIMIT(RD_TIMEOUT_CYC)) u_rd_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (rd_en),
        .clear  (bus.reg_rvalid),
        .expire (rd_expire)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        data_d   = data_q;
        resp_d   = resp_q;
        err_inc  = 1'b0;
        reg_we   = 1'b0;
        reg_re   = 1'b0;
        tx_valid = 1'b0;
`ifdef GWCT_UART_CMD_CSUM_EN
        csum_d   = csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    op_d = bus.rx_data;
                    if (is_cmd_op(bus.rx_data)) begin
                        state_d = ST_GET_ADDR;
`ifdef GWCT_UART_CMD_CSUM_EN
                        csum_d  = bus.rx_data;
`endif
                    end else begin
                        resp_d  = RSP_ERR;
                        err_inc = 1'b1;
                        state_d = ST_SEND;
                    end
                end
            end

            ST_GET_ADDR: begin
                if (bus.rx_valid) begin
                    addr_d = bus.rx_data;
`ifdef GWCT_UART_CMD_CSUM_EN
                    csum_d = csum_q ^ bus.rx_data;
                    state_d = (op_q == OP_WR) ? ST_GET_DATA : ST_GET_CSUM;
`else
                    state_d = (op_q == OP_WR) ? ST_GET_DATA : ST_BUS_RD;
`endif
                end else if (ib_expire) begin
                    err_inc = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_GET_DATA: begin
                if (bus.rx_valid) begin
                    data_d = bus.rx_data;
`ifdef GWCT_UART_CMD_CSUM_EN
                    csum_d  = csum_q ^ bus.rx_data;
                    state_d = ST_GET_CSUM;
`else
                    state_d = ST_BUS_WR;
`endif
                end else if (ib_expire) begin
                    err_inc = 1'b1;
                    state_d = ST_IDLE;
                end
            end

`ifdef GWCT_UART_CMD_CSUM_EN
            ST_GET_CSUM: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == csum_q) begin
                        state_d = (op_q == OP_WR) ? ST_BUS_WR : ST_BUS_RD;
                    end else begin
                        resp_d  = RSP_ERR;
                        err_inc = 1'b1;
                        state_d = ST_SEND;
                    end
                end else if (ib_expire) begin
                    err_inc = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`endif

            ST_BUS_WR: begin
                reg_we  = 1'b1;
                resp_d  = RSP_OK;
                state_d = ST_SEND;
            end

            ST_BUS_RD: begin
                reg_re  = 1'b1;
                state_d = ST_WAIT_RD;
            end

            ST_WAIT_RD: begin
                // Data arriving in the expiry cycle takes priority over the timeout.
                if (bus.reg_rvalid) begin
                    resp_d  = bus.reg_rdata;
                    state_d = ST_SEND;
                end else if (rd_expire) begin
                    resp_d  = RSP_ERR;
                    err_inc = 1'b1;
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                if (bus.tx_ready) begin
                    tx_valid = 1'b1;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bytes arriving while a command is executing or answering are dropped.
        if (bus.rx_valid && ((state_q == ST_BUS_WR) || (state_q == ST_BUS_RD) ||
                             (state_q == ST_WAIT_RD) || (state_q == ST_SEND))) begin
            err_inc = 1'b1;
        end

        err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            resp_q  <= '0;
            err_q   <= '0;
`ifdef GWCT_UART_CMD_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
`ifdef GWCT_UART_CMD_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // resp_q only changes when a new response is decided, so tx_data holds the
    // last response between commands.
    assign bus.tx_data   = resp_q;
    assign bus.tx_valid  = tx_valid;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = data_q;
    assign bus.reg_we    = reg_we;
    assign bus.reg_re    = reg_re;
    assign busy          = (state_q != ST_IDLE);
    assign err_cnt       = err_q;

endmodule
